// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: ALU opcodes,
// command kinds and the controller state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic CMD_ALU = 1'b0;
  localparam logic CMD_LDI = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_AB = 2'd1,
    EXEC    = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command, response and external-ALU signals of the ALU sequencing controller.
// master = the controller itself, slave = command source plus the ALU.
interface alu_seq_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_kind;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [DW-1:0] cmd_imm;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_z;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_z;
  logic          z_flag;

  modport master (
    input  cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_z,
    output rsp_valid, rsp_data, rsp_z, z_flag,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_z,
    input  rsp_valid, rsp_data, rsp_z, z_flag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// General register file: one synchronous write port, two combinational
// read ports, cleared asynchronously on reset.
module alu_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences register-level commands through an external combinational ALU.
//   state   | meaning
//   IDLE    | ready for a command; load-immediate completes here
//   LOAD_AB | operand registers A/B loaded from rs1/rs2
//   EXEC    | ALU inputs stable; result and Z captured, written to rd
//   RESP    | result offered on rsp_*, held until rsp_ready
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_seq_ctrl_if.master     bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [1:0]    op_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic          zr_q, z_flag_q;

  logic          cmd_ready, rsp_valid;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic          accept;

  assign accept = bus.cmd_valid && (state_q == IDLE);

  alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs1_q),
    .rdata_a (rf_rdata_a),
    .raddr_b (rs2_q),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = (bus.cmd_kind == CMD_LDI) ? RESP : LOAD_AB;
      LOAD_AB: state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register write happens either at the accept edge (immediate) or the EXEC edge (ALU result).
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rd_q;
    rf_wdata  = bus.alu_out;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid && bus.cmd_kind == CMD_LDI) begin
          rf_we    = 1'b1;
          rf_waddr = bus.cmd_rd;
          rf_wdata = bus.cmd_imm;
        end
      end
      EXEC:    rf_we = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      zr_q     <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.cmd_op;
            rd_q  <= bus.cmd_rd;
            rs1_q <= bus.cmd_rs1;
            rs2_q <= bus.cmd_rs2;
            if (bus.cmd_kind == CMD_LDI) begin
              c_q      <= bus.cmd_imm;
              zr_q     <= (bus.cmd_imm == '0);
              z_flag_q <= (bus.cmd_imm == '0);
            end
          end
        end
        LOAD_AB: begin
          a_q <= rf_rdata_a;
          b_q <= rf_rdata_b;
        end
        EXEC: begin
          c_q      <= bus.alu_out;
          zr_q     <= bus.alu_z;
          z_flag_q <= bus.alu_z;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = c_q;
  assign bus.rsp_z     = zr_q;
  assign bus.z_flag    = z_flag_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus random command stream,
// checked against an architectural register/flag model.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  alu_seq_ctrl_if #(.DW(16), .AW(3)) bus ();

  alu_seq_ctrl #(.DW(16), .NREG(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational ALU
  logic [15:0] alu_res;
  always_comb begin
    alu_res = 16'h0000;
    case (bus.alu_op)
      2'b00:   alu_res = bus.alu_a + bus.alu_b;
      2'b01:   alu_res = bus.alu_a - bus.alu_b;
      2'b10:   alu_res = bus.alu_a & bus.alu_b;
      default: alu_res = ~bus.alu_b;
    endcase
  end
  assign bus.alu_out = alu_res;
  assign bus.alu_z   = (alu_res == 16'h0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model
  int  mreg [8];
  bit  mz;
  int  last_acc;
  bit  last_kind;
  bit  space_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input logic [1:0] op, input int a, input int b);
    case (op)
      2'b00:   return (a + b) % 65536;
      2'b01:   return (a - b + 65536) % 65536;
      2'b10:   return a & b;
      default: return 65535 - b;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    mz       = 1'b0;
    space_ok = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_z_flag"},    bus.z_flag,    0);
    check({tag, "_alu_op"},    bus.alu_op,    0);
    check({tag, "_alu_a"},     bus.alu_a,     0);
    check({tag, "_alu_b"},     bus.alu_b,     0);
    check({tag, "_rsp_data"},  bus.rsp_data,  0);
  endtask

  task automatic run_cmd(input bit kind, input logic [1:0] op, input int rd, input int rs1,
                         input int rs2, input logic [15:0] imm, input int hold);
    int a, b, exp, waited, acc;
    bit exp_z;
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_kind  = kind;
    bus.cmd_op    = op;
    bus.cmd_rd    = 3'(rd);
    bus.cmd_rs1   = 3'(rs1);
    bus.cmd_rs2   = 3'(rs2);
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 1'($urandom);
    bus.cmd_rd    = 3'($urandom);
    bus.cmd_imm   = 16'($urandom);
    if (space_ok) check("accept_spacing", acc - last_acc, last_kind ? 2 : 4);
    last_acc  = acc;
    last_kind = kind;

    a = mreg[rs1];
    b = mreg[rs2];
    exp = kind ? int'(imm) : ref_alu(op, a, b);
    exp_z = (exp == 0);
    mreg[rd] = exp;
    mz = exp_z;

    waited = 0;
    @(negedge clk);
    while (!bus.rsp_valid && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    check("rsp_latency", waited, kind ? 0 : 2);
    check("rsp_data", bus.rsp_data, exp);
    check("rsp_z", bus.rsp_z, exp_z);
    check("z_flag", bus.z_flag, mz);
    if (!kind) begin
      check("alu_a", bus.alu_a, a);
      check("alu_b", bus.alu_b, b);
      check("alu_op", bus.alu_op, op);
    end

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = (h == 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_data", bus.rsp_data, exp);
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("back_to_idle", bus.rsp_valid, 0);
    space_ok = (hold == 0);
  endtask

  task automatic check_reg(input int r);
    run_cmd(CMD_ALU, ALU_AND, r, r, r, 16'h0, 0);
  endtask

  initial begin
    logic [15:0] imm;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    last_acc = 0;
    last_kind = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_kind  = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Wrapping subtract
    run_cmd(CMD_LDI, 2'b00, 1, 0, 0, 16'h0002, 0);
    run_cmd(CMD_LDI, 2'b00, 2, 0, 0, 16'h0004, 0);
    run_cmd(CMD_ALU, ALU_SUB, 3, 1, 2, 16'h0, 0);
    check_reg(3);

    // Add overflow to zero, then LDI clears z_flag
    run_cmd(CMD_LDI, 2'b00, 4, 0, 0, 16'h8000, 0);
    run_cmd(CMD_ALU, ALU_ADD, 5, 4, 4, 16'h0, 0);
    run_cmd(CMD_LDI, 2'b00, 6, 0, 0, 16'h0001, 0);

    run_cmd(CMD_LDI, 2'b00, 1, 0, 0, 16'h8265, 0);
    run_cmd(CMD_LDI, 2'b00, 2, 0, 0, 16'h8221, 0);
    run_cmd(CMD_ALU, ALU_AND, 7, 1, 2, 16'h0, 0);
    run_cmd(CMD_ALU, ALU_SUB, 7, 1, 2, 16'h0, 0);
    run_cmd(CMD_LDI, 2'b00, 2, 0, 0, 16'h1993, 0);
    run_cmd(CMD_ALU, ALU_NOT, 7, 1, 2, 16'h0, 0);

    // Response back-pressure
    run_cmd(CMD_ALU, ALU_ADD, 0, 1, 2, 16'h0, 5);

    // In-place update reads the old value
    run_cmd(CMD_LDI, 2'b00, 1, 0, 0, 16'h0003, 0);
    run_cmd(CMD_ALU, ALU_ADD, 1, 1, 1, 16'h0, 0);

    // Reset during EXEC
    run_cmd(CMD_LDI, 2'b00, 5, 0, 0, 16'h1234, 0);
    @(negedge clk);
    bus.cmd_kind  = CMD_ALU;
    bus.cmd_op    = ALU_ADD;
    bus.cmd_rd    = 3'd5;
    bus.cmd_rs1   = 3'd1;
    bus.cmd_rs2   = 3'd1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_exec");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reg(5);
    run_cmd(CMD_LDI, 2'b00, 2, 0, 0, 16'h0010, 0);
    run_cmd(CMD_ALU, ALU_SUB, 3, 2, 5, 16'h0, 0);

    // Random command stream
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0:       imm = 16'h0000;
        1:       imm = 16'h8000;
        2:       imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      run_cmd(($urandom_range(0, 3) == 0) ? CMD_LDI : CMD_ALU, 2'($urandom),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              imm, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    for (int r = 0; r < 8; r++) check_reg(r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
